// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 size codes, FSM states
// and the access-timeout counter width.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// The LSU is the slave; the core/memory environment is the master.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    output stall, done, err, rdata, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    input  stall, done, err, rdata, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/replication, request legality,
// and load byte/halfword extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [1:0]  req_addr_lo_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        bad_o,
  output logic [31:0] ld_data_o
);

  logic [3:0]  strb_s;
  logic        misalign_s;
  logic        illegal_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store lane steering and size/alignment legality of the live request.
  always_comb begin
    strb_s     = 4'b0000;
    wdata_o    = req_wdata_i;
    misalign_s = 1'b0;
    illegal_s  = 1'b0;
    case (req_funct3_i)
      F3_B, F3_BU: begin
        strb_s  = 4'b0001 << req_addr_lo_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      F3_H, F3_HU: begin
        misalign_s = req_addr_lo_i[0];
        strb_s     = req_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{req_wdata_i[15:0]}};
      end
      F3_W: begin
        misalign_s = (req_addr_lo_i != 2'b00);
        strb_s     = 4'b1111;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Unsigned variants exist only for loads.
  assign wstrb_o = req_we_i ? strb_s : 4'b0000;
  assign bad_o   = misalign_s | illegal_s | (req_we_i & req_funct3_i[2]);

  // Byte lane selection for the registered load offset.
  always_comb begin
    case (ld_addr_lo_i)
      2'b00:   byte_s = mem_rdata_i[7:0];
      2'b01:   byte_s = mem_rdata_i[15:8];
      2'b10:   byte_s = mem_rdata_i[23:16];
      default: byte_s = mem_rdata_i[31:24];
    endcase
  end

  assign half_s = ld_addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  // Width-dependent sign or zero extension.
  always_comb begin
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   ld_data_o = {24'h00_0000, byte_s};
      F3_H:    ld_data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   ld_data_o = {16'h0000, half_s};
      default: ld_data_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns sized core accesses into word-aligned strobed memory
// transactions, stalls the core until completion, error or timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
)
(
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave lsu
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             mem_req_q;
  logic             done_q;
  logic             err_q;

  logic [3:0]       wstrb_s;
  logic [31:0]      wdata_s;
  logic             bad_s;
  logic [31:0]      ld_data_s;

  lsu_lane_align u_align (
    .req_we_i      (lsu.req_we),
    .req_funct3_i  (lsu.req_funct3),
    .req_addr_lo_i (lsu.req_addr[1:0]),
    .req_wdata_i   (lsu.req_wdata),
    .ld_funct3_i   (funct3_q),
    .ld_addr_lo_i  (addr_lo_q),
    .mem_rdata_i   (lsu.mem_rdata),
    .wstrb_o       (wstrb_s),
    .wdata_o       (wdata_s),
    .bad_o         (bad_s),
    .ld_data_o     (ld_data_s)
  );

  // Access FSM; every output except stall is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      mem_addr_q <= 32'h0000_0000;
      wstrb_q    <= 4'b0000;
      wdata_q    <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      mem_req_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (lsu.req_valid) begin
            if (bad_s) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q    <= ACCESS;
              cnt_q      <= '0;
              we_q       <= lsu.req_we;
              funct3_q   <= lsu.req_funct3;
              addr_lo_q  <= lsu.req_addr[1:0];
              mem_addr_q <= {lsu.req_addr[31:2], 2'b00};
              wstrb_q    <= wstrb_s;
              wdata_q    <= wdata_s;
              mem_req_q  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // Ready wins over a simultaneous timeout.
          if (lsu.mem_ready) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            if (!we_q) begin
              rdata_q <= ld_data_s;
            end
          end else if (cnt_q == TMO_LAST) begin
            state_q   <= RESP;
            cnt_q     <= cnt_q + CNT_W'(1);
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
        end
      endcase
    end
  end

  assign lsu.stall     = (state_q == ACCESS) | ((state_q == IDLE) & lsu.req_valid);
  assign lsu.done      = done_q;
  assign lsu.err       = err_q;
  assign lsu.rdata     = rdata_q;
  assign lsu.mem_req   = mem_req_q;
  assign lsu.mem_we    = we_q;
  assign lsu.mem_addr  = mem_addr_q;
  assign lsu.mem_wstrb = wstrb_q;
  assign lsu.mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level expectation model
// and a per-cycle compare process.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if if_m ();
  load_store_unit_if if_t ();

  load_store_unit #(.TIMEOUT(255)) dut (.clk(clk), .reset(reset), .lsu(if_m));
  load_store_unit #(.TIMEOUT(4))   dut_t (.clk(clk), .reset(reset), .lsu(if_t));

  int tests_run = 0;
  int failures  = 0;

  typedef struct {
    bit          we;
    bit          bad;
    bit          uses_mem;
    bit          err;
    bit          loads;
    int          done_cyc;
    logic [31:0] maddr;
    logic [3:0]  strb;
    logic [31:0] wrep;
    logic [31:0] ld;
  } exp_t;

  exp_t        cur;
  bit          active = 1'b0;
  bit          chk_en = 1'b0;
  int          cyc = 0;
  logic [31:0] model_rdata = 32'h0;
  int          obs_done_cyc;
  bit          obs_err;
  bit          obs_memreq;
  logic [31:0] obs_maddr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_strb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome of one request from size/sign rules and the ready delay.
  function automatic exp_t predict(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] mrd,
                                   input int delay, input int tmo);
    exp_t e;
    int nb, off;
    bit sgn, legal;
    logic [31:0] v, mask;
    nb = 4; sgn = 1'b0; legal = 1'b1; off = int'(addr[1:0]);
    case (f3)
      3'b000: begin nb = 1; sgn = 1'b1; end
      3'b001: begin nb = 2; sgn = 1'b1; end
      3'b010: nb = 4;
      3'b100: begin nb = 1; legal = !we; end
      3'b101: begin nb = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    e.we       = we;
    e.bad      = !legal || (off % nb != 0);
    e.uses_mem = !e.bad;
    e.err      = e.bad || (delay >= tmo);
    e.done_cyc = e.bad ? 1 : ((delay < tmo) ? delay + 2 : tmo + 1);
    e.maddr    = addr & 32'hFFFF_FFFC;
    e.strb     = 4'b0000;
    if (we && !e.bad)
      for (int i = 0; i < nb; i++) e.strb[off + i] = 1'b1;
    for (int i = 0; i < 4; i++) e.wrep[8*i +: 8] = wdata[8*(i % nb) +: 8];
    v = mrd >> (8 * off);
    if (nb < 4) begin
      mask = (32'd1 << (8 * nb)) - 32'd1;
      v = v & mask;
      if (sgn && v[8*nb-1]) v = v | ~mask;
    end
    e.ld    = v;
    e.loads = !we && !e.err;
    return e;
  endfunction

  // Per-cycle comparison of the main DUT against the current expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      if (active) begin
        bit mreq;
        mreq = cur.uses_mem && (cyc >= 1) && (cyc < cur.done_cyc);
        check("stall", if_m.stall, cyc < cur.done_cyc);
        check("done", if_m.done, cyc == cur.done_cyc);
        check("mem_req", if_m.mem_req, mreq);
        if (cyc == cur.done_cyc) begin
          check("err", if_m.err, cur.err);
          obs_done_cyc = cyc;
          obs_err = if_m.err;
        end
        if (mreq) begin
          check("mem_addr", if_m.mem_addr, cur.maddr);
          check("mem_we", if_m.mem_we, cur.we);
          check("mem_wstrb", if_m.mem_wstrb, cur.strb);
          if (cur.we) check("mem_wdata", if_m.mem_wdata, cur.wrep);
        end
        if (if_m.mem_req) begin
          obs_memreq = 1'b1;
          obs_maddr = if_m.mem_addr;
          obs_strb = if_m.mem_wstrb;
          obs_wdata = if_m.mem_wdata;
        end
        check("rdata", if_m.rdata, (cyc >= cur.done_cyc && cur.loads) ? cur.ld : model_rdata);
      end else begin
        check("idle_stall", if_m.stall, if_m.req_valid);
        check("idle_done", if_m.done, 1'b0);
        check("idle_mem_req", if_m.mem_req, 1'b0);
        check("idle_rdata", if_m.rdata, model_rdata);
      end
    end
  end

  task automatic run(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] mrd, input int delay,
                     input bit drop_valid);
    cur = predict(we, f3, addr, wdata, mrd, delay, 255);
    obs_done_cyc = -1; obs_err = 1'b0; obs_memreq = 1'b0;
    obs_maddr = 32'h0; obs_strb = 4'h0; obs_wdata = 32'h0;
    @(posedge clk); #1;
    if_m.req_valid = 1'b1; if_m.req_we = we; if_m.req_funct3 = f3;
    if_m.req_addr = addr; if_m.req_wdata = wdata; if_m.mem_rdata = mrd;
    if_m.mem_ready = 1'b0;
    cyc = 0; active = 1'b1;
    for (int c = 1; c <= cur.done_cyc; c++) begin
      @(posedge clk); #1;
      cyc = c;
      if_m.mem_ready = (c == delay + 1);
      if (drop_valid) if_m.req_valid = 1'b0;
    end
    @(posedge clk); #1;
    active = 1'b0; if_m.req_valid = 1'b0; if_m.mem_ready = 1'b0;
    if (cur.loads) model_rdata = cur.ld;
  endtask

  // Word load on the TIMEOUT=4 instance, checked cycle by cycle.
  task automatic run_t(input logic [31:0] addr, input logic [31:0] mrd, input int delay,
                       input int exp_done_cyc, input bit exp_err);
    exp_t e;
    int seen;
    e = predict(1'b0, F3_W, addr, 32'h0, mrd, delay, 4);
    check("t_model_done_cyc", e.done_cyc, exp_done_cyc);
    seen = -1;
    @(posedge clk); #1;
    if_t.req_valid = 1'b1; if_t.req_we = 1'b0; if_t.req_funct3 = F3_W;
    if_t.req_addr = addr; if_t.req_wdata = 32'h0; if_t.mem_rdata = mrd; if_t.mem_ready = 1'b0;
    for (int c = 0; c <= e.done_cyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if_t.mem_ready = (c == delay + 1);
      end
      @(negedge clk);
      check("t_mem_req", if_t.mem_req, (c >= 1) && (c < e.done_cyc));
      check("t_stall", if_t.stall, c < e.done_cyc);
      if (if_t.done) begin
        seen = c;
        check("t_err", if_t.err, exp_err);
      end
    end
    check("t_done_cyc", seen, exp_done_cyc);
    if (!exp_err) check("t_rdata", if_t.rdata, mrd);
    @(posedge clk); #1;
    if_t.req_valid = 1'b0; if_t.mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    if_m.req_valid = 1'b0; if_m.req_we = 1'b0; if_m.req_funct3 = 3'b000;
    if_m.req_addr = 32'h0; if_m.req_wdata = 32'h0; if_m.mem_ready = 1'b0; if_m.mem_rdata = 32'h0;
    if_t.req_valid = 1'b0; if_t.req_we = 1'b0; if_t.req_funct3 = 3'b000;
    if_t.req_addr = 32'h0; if_t.req_wdata = 32'h0; if_t.mem_ready = 1'b0; if_t.mem_rdata = 32'h0;
    #12;
    check("rst_stall", if_m.stall, 1'b0);
    check("rst_done", if_m.done, 1'b0);
    check("rst_err", if_m.err, 1'b0);
    check("rst_rdata", if_m.rdata, 32'h0);
    check("rst_mem_req", if_m.mem_req, 1'b0);
    check("rst_mem_we", if_m.mem_we, 1'b0);
    check("rst_mem_addr", if_m.mem_addr, 32'h0);
    check("rst_mem_wstrb", if_m.mem_wstrb, 4'h0);
    check("rst_mem_wdata", if_m.mem_wdata, 32'h0);
    @(negedge clk); reset = 1'b1; chk_en = 1'b1;

    run(1'b1, F3_W, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    check("sw_addr", obs_maddr, 32'h0000_0104);
    check("sw_strb", obs_strb, 4'b1111);
    check("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
    check("sw_done_cyc", obs_done_cyc, 2);
    check("sw_err", obs_err, 1'b0);

    run(1'b1, F3_B, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0, 1'b0);
    check("sb_addr", obs_maddr, 32'h0000_0200);
    check("sb_strb", obs_strb, 4'b1000);
    check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);

    run(1'b0, F3_B, 32'h0000_0302, 32'h0, 32'h12F0_3456, 0, 1'b0);
    check("lb_rdata", if_m.rdata, 32'hFFFF_FFF0);
    run(1'b0, F3_BU, 32'h0000_0302, 32'h0, 32'h12F0_3456, 0, 1'b0);
    check("lbu_rdata", if_m.rdata, 32'h0000_00F0);
    run(1'b0, F3_H, 32'h0000_0302, 32'h0, 32'h12F0_3456, 5, 1'b0);
    check("lh_rdata", if_m.rdata, 32'h0000_12F0);
    check("lh_done_cyc", obs_done_cyc, 7);

    run(1'b0, F3_W, 32'h0000_0106, 32'h0, 32'h5555_5555, 0, 1'b0);
    check("lw_mis_memreq", obs_memreq, 1'b0);
    check("lw_mis_err", obs_err, 1'b1);
    check("lw_mis_done_cyc", obs_done_cyc, 1);
    check("lw_mis_rdata", if_m.rdata, 32'h0000_12F0);

    run(1'b1, F3_H, 32'h0000_0302, 32'h0000_BEEF, 32'h0, 2, 1'b0);
    check("sh_strb", obs_strb, 4'b1100);
    check("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
    run(1'b0, F3_H, 32'h0000_0300, 32'h0, 32'hA5A5_8001, 1, 1'b0);
    check("lh_neg_rdata", if_m.rdata, 32'hFFFF_8001);
    run(1'b0, F3_HU, 32'h0000_0300, 32'h0, 32'hA5A5_8001, 0, 1'b0);
    check("lhu_rdata", if_m.rdata, 32'h0000_8001);
    run(1'b0, F3_W, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 1, 1'b1);
    check("lw_drop_rdata", if_m.rdata, 32'hCAFE_F00D);

    run(1'b0, 3'b011, 32'h0000_0400, 32'h0, 32'h0, 0, 1'b0);
    check("f3_011_err", obs_err, 1'b1);
    run(1'b1, F3_BU, 32'h0000_0400, 32'h0, 32'h0, 0, 1'b0);
    check("sbu_err", obs_err, 1'b1);
    run(1'b0, F3_H, 32'h0000_0301, 32'h0, 32'h0, 0, 1'b0);
    check("lh_mis_err", obs_err, 1'b1);
    run(1'b1, F3_W, 32'h0000_0102, 32'h1234_5678, 32'h0, 0, 1'b0);
    check("sw_mis_memreq", obs_memreq, 1'b0);
    run(1'b0, 3'b111, 32'h0000_0400, 32'h0, 32'h0, 0, 1'b0);
    check("f3_111_err", obs_err, 1'b1);

    // Stray ready while idle must not produce a response.
    @(posedge clk); #1; if_m.mem_ready = 1'b1;
    @(posedge clk); #1; if_m.mem_ready = 1'b0;

    run_t(32'h0000_0500, 32'h1122_3344, 100, 5, 1'b1);
    run_t(32'h0000_0504, 32'h1122_3344, 3, 5, 1'b0);

    chk_en = 1'b0;
    @(posedge clk); #1;
    if_m.req_valid = 1'b1; if_m.req_we = 1'b0; if_m.req_funct3 = F3_W;
    if_m.req_addr = 32'h0000_0600; if_m.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_pre_memreq", if_m.mem_req, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_memreq", if_m.mem_req, 1'b0);
    check("rst_mid_done", if_m.done, 1'b0);
    check("rst_mid_rdata", if_m.rdata, 32'h0);
    if_m.req_valid = 1'b0;
    model_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", if_m.done, 1'b0);
      check("post_rst_memreq", if_m.mem_req, 1'b0);
      check("post_rst_stall", if_m.stall, 1'b0);
    end
    chk_en = 1'b1;
    run(1'b0, F3_BU, 32'h0000_0701, 32'h0, 32'h0000_7F00, 0, 1'b0);
    check("post_rst_lbu", if_m.rdata, 32'h0000_007F);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle core datapath (ALU address, rs2 data, funct3) and a variable-latency data memory.
- Converts byte, halfword and word loads/stores into word-aligned memory transactions with byte strobes.
- Sign- or zero-extends load data.
- Holds the core in stall until each access completes, errors or times out.

Parameters:
TIMEOUT, 255, max cycles waiting for mem_ready before the access is aborted with an error (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  core requests a memory access; held with stable inputs until done
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32 size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
req_addr  input  32  byte address from ALU
req_wdata  input  32  store data (rs2), right-justified
stall  output  1  core must hold PC and suppress writeback
done  output  1  one-cycle pulse: access finished
err  output  1  valid with done: misaligned, illegal funct3 or timeout
rdata  output  32  extended load data, valid with done and held until next done
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  memory write enable
mem_addr  output  32  word address ({req_addr[31:2], 2'b00})
mem_wstrb  output  4  byte enables for stores; 4'b0000 on loads
mem_wdata  output  32  store data replicated into the addressed lanes
mem_ready  input  1  memory completes the current request this cycle
mem_rdata  input  32  read word, valid when mem_ready on a load

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including rdata and the timeout counter.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - stall = req_valid.
  - On req_valid, the block checks alignment and funct3:
    - Halfword requires addr[0]=0. Word requires addr[1:0]=00.
    - funct3 011, 110 or 111 is illegal. Stores with funct3 bit 2 set are illegal.
  - Illegal or misaligned: next state is RESP with err=1. There is no memory access and rdata is unchanged.
  - Otherwise the block registers the request:
    - It registers we, funct3, addr[1:0], the word address, strobes and lane-replicated wdata.
    - Next state is ACCESS.
- ACCESS:
  - mem_req=1 and stall=1. mem_* outputs come from registered values and are stable for the whole state.
  - The counter increments each cycle that mem_ready=0.
  - mem_ready=1: the block captures extended load data into rdata (loads only) and goes to RESP with err=0.
  - Counter reaches TIMEOUT with mem_ready still 0: the block drops mem_req and goes to RESP with err=1.
  - Ready arriving in the same cycle as the timeout counts as success.
- RESP:
  - done=1 for exactly one cycle and stall=0.
  - err is valid for that cycle only.
  - Next state is IDLE unconditionally.
  - A new req_valid is not sampled in RESP. The core advances on done.
- Latency:
  - Minimum is 3 cycles from req_valid to done (IDLE → ACCESS with ready on the first ACCESS cycle → RESP).
  - The error path takes 2 cycles.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
- Load extract:
  - The block selects a byte or halfword by addr[1:0].
  - LB and LH sign-extend. LBU and LHU zero-extend. LW passes the word through.
- mem_ready outside ACCESS is ignored.
- req_valid dropping mid-access does not abort. The access completes and done still pulses.
- Reset mid-ACCESS:
  - mem_req deasserts immediately (asynchronously).
  - No done is produced.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state enum (IDLE, ACCESS, RESP).
  - The counter width constant.
- One combinational sub-module, lsu_lane_align:
  - Generates store strobes and lane-replicated write data.
  - Extracts and extends load data.
  - Flags misaligned and illegal requests.
  - Is instantiated once.

Test Plan:
- SW: addr 0x0000_0104, wdata 0xDEADBEEF, mem_ready on the 1st ACCESS cycle → mem_addr 0x104, wstrb 1111, wdata 0xDEADBEEF; done 3 cycles after req_valid; err=0.
- SB: addr 0x0000_0203, wdata 0x0000_00A5 → mem_addr 0x200, wstrb 1000, mem_wdata 0xA5A5A5A5.
- Byte loads at addr 0x0000_0302 with mem_rdata 0x12F0_3456 → LB gives rdata 0xFFFF_FFF0; LBU gives 0x0000_00F0.
- Halfword loads at addr 0x302, same mem_rdata, with mem_ready delayed 5 cycles:
  - LH gives rdata 0x0000_12F0.
  - stall stays high throughout.
  - done comes 8 cycles after req_valid.
- LW at addr 0x0000_0106 → mem_req is never asserted; done and err=1 two cycles after req_valid; rdata keeps its previous value.
- Timeout: TIMEOUT=4 with mem_ready held low → err=1 with done, mem_req deasserted.
- Reset asserted during ACCESS → mem_req=0 immediately; state is IDLE after reset release; no done pulse.
